// File: rtl/vec_alu_lane.sv
// ----------------------------------------------------------------------------
// vec_alu_lane
//   One lane of the vector execution unit. Each cycle it computes one chunk of
//   vd = vs2 op vs1, where op is an RVV OPIVV funct6 code. A chunk is
//   min(SEW, 2^LANE_WIDTH) bits wide. Chunks are walked LSB-first. Add and sub
//   chain a carry between chunks of the same element. Several lanes can share
//   one vector by interleaving chunks: this lane owns chunks
//   LANE_I + j*2^NB_LANES.
//
// Ports
//   clk     in   1     clock, rising edge
//   resetn  in   1     asynchronous reset, active-high (despite the name)
//   opcode  in   6     funct6 operation code
//   run     in   1     1 = execute, 0 = clear and re-arm
//   vs1     in   VLEN  source operand 1
//   vs2     in   VLEN  source operand 2
//   vsew    in   3     element width select, SEW = 8 << vsew (4..7 -> 64)
//   vd      out  VLEN  result register
//   done    out  1     registered completion flag
// ----------------------------------------------------------------------------
module vec_alu_lane #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 4,
    parameter int NB_LANES   = 0,
    parameter int LANE_I     = 0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [5:0]      opcode,
    input  logic            run,
    input  logic [VLEN-1:0] vs1,
    input  logic [VLEN-1:0] vs2,
    input  logic [2:0]      vsew,
    output logic [VLEN-1:0] vd,
    output logic            done
);

    localparam int W     = 1 << LANE_WIDTH;         // datapath width
    localparam int CNT_W = $clog2(VLEN / 8) + 1;    // worst case: 8-bit chunks
    localparam int OFF_W = $clog2(VLEN) + 1;

    typedef enum logic [5:0] {
        OP_VADD = 6'b000000,
        OP_VSUB = 6'b000010,
        OP_VAND = 6'b001001,
        OP_VOR  = 6'b001010,
        OP_VXOR = 6'b001011
    } op_e;

    logic [VLEN-1:0]   vd_q,    vd_d;
    logic              done_q,  done_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              carry_q, carry_d;

    logic [2:0]            sew_log;     // log2(SEW)
    logic [2:0]            c_log;       // log2(chunk width)
    logic [LANE_WIDTH:0]   c_bits;      // chunk width in bits
    logic [W-1:0]          c_mask;
    logic [31:0]           t_cycles;
    logic [OFF_W-1:0]      chunk_idx;
    logic [OFF_W-1:0]      off;
    logic                  elem_start;
    logic [W-1:0]          a, b, b_in, res;
    logic                  cin;
    logic [W:0]            sum;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        sew_log    = vsew[2] ? 3'd6 : 3'd3 + {1'b0, vsew[1:0]};
        c_log      = (sew_log > 3'(LANE_WIDTH)) ? 3'(LANE_WIDTH) : sew_log;
        c_bits     = (LANE_WIDTH+1)'(1) << c_log;
        c_mask     = W'(((W+1)'(1) << c_bits) - (W+1)'(1));
        t_cycles   = 32'(VLEN) >> (32'(c_log) + 32'(NB_LANES));

        chunk_idx  = OFF_W'(LANE_I) + (OFF_W'(cnt_q) << NB_LANES);
        off        = chunk_idx << c_log;
        // A chunk opens a new element when its bit offset is a multiple of SEW.
        elem_start = (off & ((OFF_W'(1) << sew_log) - OFF_W'(1))) == '0;

        a          = W'(vs2 >> off) & c_mask;
        b          = W'(vs1 >> off) & c_mask;
        b_in       = b;
        cin        = elem_start ? 1'b0 : carry_q;
        res        = '0;
        carry_d    = 1'b0;

        // Subtraction is vs2 + ~vs1 + 1; the +1 enters as carry-in at the
        // element's first chunk and then ripples like an ordinary carry.
        if (opcode == OP_VSUB) begin
            b_in = ~b & c_mask;
            cin  = elem_start ? 1'b1 : carry_q;
        end
        sum = {1'b0, a} + {1'b0, b_in} + {{W{1'b0}}, cin};

        case (opcode)
            OP_VADD, OP_VSUB: begin
                res     = sum[W-1:0] & c_mask;
                carry_d = sum[c_bits];          // carry out of the C-bit chunk
            end
            OP_VAND: res = a & b;
            OP_VOR:  res = a | b;
            OP_VXOR: res = a ^ b;
            default: res = '0;
        endcase

        vd_d   = (vd_q & ~(VLEN'(c_mask) << off)) | (VLEN'(res) << off);
        cnt_d  = cnt_q + CNT_W'(1);
        done_d = (32'(cnt_q) == t_cycles - 32'd1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            vd_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (!run) begin
            vd_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (!done_q) begin
            vd_q    <= vd_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign vd   = vd_q;
    assign done = done_q;

endmodule

// File: tb/tb_vec_alu_lane.sv
// ----------------------------------------------------------------------------
// tb_vec_alu_lane
//   Self-checking bench for vec_alu_lane at default parameters (VLEN=128,
//   16-bit lane, single lane). Expected results come from an element-wise
//   reference model working on whole SEW-bit integers.
// ----------------------------------------------------------------------------
module tb_vec_alu_lane;

    localparam int VLEN = 128;
    localparam int LW   = 4;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic [5:0]      opcode = '0;
    logic            run = 1'b0;
    logic [VLEN-1:0] vs1 = '0;
    logic [VLEN-1:0] vs2 = '0;
    logic [2:0]      vsew = '0;
    logic [VLEN-1:0] vd;
    logic            done;

    int n_checks = 0;
    int n_fail   = 0;

    vec_alu_lane #(.VLEN(VLEN), .LANE_WIDTH(LW), .NB_LANES(0), .LANE_I(0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .opcode (opcode),
        .run    (run),
        .vs1    (vs1),
        .vs2    (vs2),
        .vsew   (vsew),
        .vd     (vd),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VLEN-1:0] got,
                         input logic [VLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sew_of(input logic [2:0] s);
        return 8 << ((s > 3'd3) ? 3 : int'(s));
    endfunction

    function automatic int t_of(input logic [2:0] s);
        int sew = sew_of(s);
        return VLEN / ((sew < (1 << LW)) ? sew : (1 << LW));
    endfunction

    // Reference: whole-element integer arithmetic modulo 2^SEW.
    function automatic logic [VLEN-1:0] model(input logic [5:0] op, input logic [2:0] s,
                                              input logic [VLEN-1:0] v1,
                                              input logic [VLEN-1:0] v2);
        int sew = sew_of(s);
        logic [63:0] m = (sew == 64) ? '1 : ((64'd1 << sew) - 64'd1);
        logic [VLEN-1:0] out = '0;
        for (int e = 0; e < VLEN / sew; e++) begin
            logic [63:0] x = 64'(v2 >> (e * sew)) & m;
            logic [63:0] y = 64'(v1 >> (e * sew)) & m;
            logic [63:0] r;
            case (op)
                6'b000000: r = x + y;
                6'b000010: r = x - y;
                6'b001001: r = x & y;
                6'b001010: r = x | y;
                6'b001011: r = x ^ y;
                default:   r = 64'd0;
            endcase
            out |= VLEN'(r & m) << (e * sew);
        end
        return out;
    endfunction

    // run=1 phase: T edges, done must rise exactly on the T-th, then hold.
    task automatic busy(input string tag, input logic [5:0] op, input logic [2:0] s,
                        input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2);
        int t = t_of(s);
        logic [VLEN-1:0] exp = model(op, s, v1, v2);
        run = 1'b1;
        for (int n = 1; n <= t; n++) begin
            edge_step();
            check($sformatf("%s done@%0d", tag, n), VLEN'(done), VLEN'(n == t));
        end
        check({tag, " vd"}, vd, exp);
        edge_step();
        check({tag, " hold vd"}, vd, exp);
        check({tag, " hold done"}, VLEN'(done), VLEN'(1));
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [2:0] s,
                          input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2);
        opcode = op; vsew = s; vs1 = v1; vs2 = v2;
        run = 1'b0;
        edge_step();
        check({tag, " idle vd"}, vd, '0);
        check({tag, " idle done"}, VLEN'(done), '0);
        busy(tag, op, s, v1, v2);
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [VLEN-1:0] A1 = 128'habcdabcdbeefbeef1234567887654321;
    localparam logic [VLEN-1:0] A2 = 128'h8765432112345678beefbeefabcdabcd;

    initial begin
        logic [VLEN-1:0] r1, r2;
        logic [5:0] ops [6] = '{6'b000000, 6'b000010, 6'b001001,
                                6'b001010, 6'b001011, 6'b111111};

        // Reset state, before any clock edge.
        #3;
        check("reset vd", vd, '0);
        check("reset done", VLEN'(done), '0);
        edge_step();
        resetn = 1'b0;

        // vand at each element width, checked against the literal answer too.
        for (int s = 0; s < 4; s++) begin
            run_op($sformatf("vand sew%0d", s), 6'b001001, 3'(s), A1, A2);
            check($sformatf("vand sew%0d literal", s), vd,
                  128'h83450301122416681224166883450301);
        end

        // vadd, 64-bit: carry ripples through the low element but not beyond.
        r2 = 128'h0000000000001234_FFFFFFFFFFFFFFFF;
        r1 = {64'd1, 64'd1};
        run_op("vadd sew64", 6'b000000, 3'd3, r1, r2);
        check("vadd sew64 literal", vd, 128'h0000000000001235_0000000000000000);

        // vsub, 8-bit: 0 - 1 wraps to FF in every byte.
        run_op("vsub sew8", 6'b000010, 3'd0, {16{8'h01}}, '0);
        check("vsub sew8 literal", vd, {16{8'hFF}});

        // Unsupported opcode.
        run_op("op111111", 6'b111111, 3'd1, A1, A2);
        check("op111111 literal", vd, '0);

        // Abort after 5 busy edges, then a full run again.
        r1 = rand_vec(); r2 = rand_vec() | 128'h1;
        opcode = 6'b000000; vsew = 3'd0; vs1 = r1; vs2 = r2;
        run = 1'b0;
        edge_step();
        run = 1'b1;
        for (int n = 1; n <= 5; n++) edge_step();
        check("abort pre done", VLEN'(done), '0);
        run = 1'b0;
        edge_step();
        check("abort vd", vd, '0);
        check("abort done", VLEN'(done), '0);
        busy("after abort", 6'b000000, 3'd0, r1, r2);

        // Asynchronous reset mid-operation.
        r1 = rand_vec() | 128'h1; r2 = rand_vec();
        opcode = 6'b001010; vsew = 3'd0; vs1 = r1; vs2 = r2;
        run = 1'b0;
        edge_step();
        run = 1'b1;
        for (int n = 1; n <= 4; n++) edge_step();
        #2 resetn = 1'b1;
        #1;
        check("async rst vd", vd, '0);
        check("async rst done", VLEN'(done), '0);
        run = 1'b0;
        edge_step();
        resetn = 1'b0;

        // Randomized operations and widths (vsew 4..7 alias to 64-bit).
        for (int i = 0; i < 30; i++) begin
            r1 = rand_vec(); r2 = rand_vec();
            run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 5)],
                   3'($urandom_range(0, 7)), r1, r2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
